// File: rtl/booth2_seq_mult.sv
// Sequential radix-4 (Booth-2) multiplier: one recoded digit per clock,
// signed or unsigned operands selected per operation, valid/ready on both sides.
module booth2_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_md,
    input  logic [WIDTH-1:0]     A_NUM,
    input  logic [WIDTH-1:0]     B_NUM,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 busy
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int PW   = 2 * WIDTH;
    localparam int EW   = WIDTH + 2;
    localparam int CW   = $clog2(NDIG + 1);

    localparam logic [1:0]    IDLE = 2'd0;
    localparam logic [1:0]    CALC = 2'd1;
    localparam logic [1:0]    DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    logic [1:0]    state;
    logic [PW-1:0] mcand;
    logic [EW:0]   digits;
    logic [PW-1:0] acc;
    logic [CW-1:0] count;

    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc_next;

    always_comb begin
        a_ext = signed_md ? {{2{A_NUM[WIDTH-1]}}, A_NUM} : {2'b00, A_NUM};
        b_ext = signed_md ? {{2{B_NUM[WIDTH-1]}}, B_NUM} : {2'b00, B_NUM};
    end

    // mcand already carries the 2*count weight, so the digit product needs no barrel shift.
    always_comb begin
        pp = '0;
        case (digits[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            state   <= IDLE;
            mcand   <= '0;
            digits  <= '0;
            acc     <= '0;
            count   <= '0;
            PRODUCT <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{(PW - EW){a_ext[EW-1]}}, a_ext};
                        digits <= {b_ext, 1'b0};
                        acc    <= '0;
                        count  <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 2;
                    digits <= {{2{digits[EW]}}, digits[EW:2]};
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        PRODUCT <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);

endmodule

// File: tb/tb_booth2_seq_mult.sv
// Bench for booth2_seq_mult: directed corner cases plus randomized traffic on a
// 16-bit and an 8-bit instance, checked through expected-product queues.
module tb_booth2_seq_mult;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        clr;

    logic        in_valid, in_ready, signed_md, out_valid, out_ready, busy;
    logic [15:0] a16, b16;
    logic [31:0] product;

    logic        in_valid8, in_ready8, signed8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp8_q[$];
    logic        rnd_on = 1'b0;

    always #5 sys_clk = ~sys_clk;

    booth2_seq_mult #(.WIDTH(16)) u_dut16 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .signed_md(signed_md),
        .A_NUM(a16), .B_NUM(b16),
        .out_valid(out_valid), .out_ready(out_ready), .PRODUCT(product), .busy(busy)
    );

    booth2_seq_mult #(.WIDTH(8)) u_dut8 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n), .clr(clr),
        .in_valid(in_valid8), .in_ready(in_ready8), .signed_md(signed8),
        .A_NUM(a8), .B_NUM(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .PRODUCT(product8), .busy(busy8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: interpret operands at width w, multiply as integers, keep 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        longint mask, sa, sb, p;
        mask = (longint'(1) <<< w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (s && ((sa >>> (w - 1)) & 1) != 0) sa = sa - (longint'(1) <<< w);
        if (s && ((sb >>> (w - 1)) & 1) != 0) sb = sb - (longint'(1) <<< w);
        p = sa * sb;
        return 64'(p & ((longint'(1) <<< (2 * w)) - 1));
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = 32'((64'd1 << w) - 1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return m;
            2: return 32'd1 << (w - 1);
            3: return 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    // Scoreboard monitors: a product is consumed at an edge where valid and ready are both high.
    always @(negedge sys_clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL w16 unexpected product: got %0h with empty queue", product);
            end else begin
                chk("w16 product", 64'(product), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge sys_clk) begin
        if (rst_n && !clr && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                checks++;
                $display("FAIL w8 unexpected product: got %0h with empty queue", product8);
            end else begin
                chk("w8 product", 64'(product8), 64'(exp8_q.pop_front()));
            end
        end
    end

    task automatic issue16(input logic [15:0] aa, input logic [15:0] bb, input logic s);
        int   n = 0;
        logic took = 1'b0;
        in_valid = 1'b1; a16 = aa; b16 = bb; signed_md = s;
        while (!took && n < 300) begin
            @(negedge sys_clk);
            if (in_ready && rst_n && !clr) begin
                took = 1'b1;
                exp_q.push_back(32'(model(16, 32'(aa), 32'(bb), s)));
            end
            @(posedge sys_clk); #1;
            n++;
        end
        in_valid = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); signed_md = 1'($urandom);
        if (!took) begin
            checks++;
            $display("FAIL w16 accept timeout: in_ready never seen for %0h*%0h", aa, bb);
        end
    endtask

    task automatic issue8(input logic [7:0] aa, input logic [7:0] bb, input logic s);
        int   n = 0;
        logic took = 1'b0;
        in_valid8 = 1'b1; a8 = aa; b8 = bb; signed8 = s;
        while (!took && n < 300) begin
            @(negedge sys_clk);
            if (in_ready8 && rst_n && !clr) begin
                took = 1'b1;
                exp8_q.push_back(16'(model(8, 32'(aa), 32'(bb), s)));
            end
            @(posedge sys_clk); #1;
            n++;
        end
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); signed8 = 1'($urandom);
        if (!took) begin
            checks++;
            $display("FAIL w8 accept timeout: in_ready never seen for %0h*%0h", aa, bb);
        end
    endtask

    // Returns the number of edges after accept until out_valid is observed (0 on timeout).
    task automatic wait_valid16(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge sys_clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_idle(input string name);
        chk(name, {60'd0, in_ready, out_valid, busy, 1'b0} | 64'(product) << 4,
            {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk({name, " w8"}, {60'd0, in_ready8, out_valid8, busy8, 1'b0} | 64'(product8) << 4,
            {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic directed_op(input string name, input logic [15:0] aa,
                               input logic [15:0] bb, input logic s);
        int lat;
        issue16(aa, bb, s);
        chk({name, " calc flags"}, {62'd0, busy, in_ready}, {62'd0, 1'b1, 1'b0});
        wait_valid16(lat);
        chk({name, " latency"}, 64'(lat), 64'd9);
        @(posedge sys_clk); #1;
    endtask

    logic [15:0] ta[6] = '{16'd3, 16'hFFFF, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic [15:0] tb[6] = '{16'd5, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h8000};
    logic        ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] tx[6] = '{32'h0000000F, 32'hFFFE0001, 32'h40000000,
                           32'hFFFFFFFF, 32'h0000FFFF, 32'hC0008000};

    initial begin
        int lat;
        int n;
        logic [31:0] e;
        rst_n = 1'b0; clr = 1'b0;
        in_valid = 1'b0; a16 = '0; b16 = '0; signed_md = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; signed8 = 1'b0; out_ready8 = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_idle("reset state");
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check_idle("after reset release");

        // Table of hand-computed products; the reference model must agree with them too.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("model vs table", model(16, 32'(ta[i]), 32'(tb[i]), ts[i]), 64'(tx[i]));
            directed_op("table op", ta[i], tb[i], ts[i]);
        end

        // Backpressure: result and handshake state must hold while out_ready is low.
        out_ready = 1'b0;
        e = 32'(model(16, 32'h1234, 32'hABCD, 1'b1));
        issue16(16'h1234, 16'hABCD, 1'b1);
        wait_valid16(lat);
        chk("t4 latency", 64'(lat), 64'd9);
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            chk("t4 hold", {30'd0, out_valid, in_ready, busy, product},
                {30'd0, 1'b1, 1'b0, 1'b1, e});
        end
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        chk("t4 release", {31'd0, out_valid, in_ready, product}, {31'd0, 1'b0, 1'b1, e});

        // Reset in the middle of an operation, then a fresh operation.
        issue16(16'h0F0F, 16'h3333, 1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        check_idle("t5 mid-op reset");
        directed_op("t5 after reset", 16'hC001, 16'h00FE, 1'b1);

        // Flush in the middle of an operation, then a fresh operation.
        issue16(16'hBEEF, 16'h1357, 1'b0);
        repeat (4) @(posedge sys_clk);
        #1;
        clr = 1'b1;
        exp_q.delete();
        @(posedge sys_clk); #1;
        clr = 1'b0;
        check_idle("t5 mid-op clr");
        directed_op("t5 after clr", 16'hFFFE, 16'h8001, 1'b0);

        // Randomized traffic on both widths with random gaps and consumer stalls.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge sys_clk); #1;
                    if (rnd_on) begin
                        out_ready  = ($urandom_range(0, 3) != 0);
                        out_ready8 = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        join_none
        fork
            begin
                for (int i = 0; i < 1200; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge sys_clk);
                    #1;
                    issue16(16'(pick(16)), 16'(pick(16)), 1'(i & 1));
                end
            end
            begin
                for (int j = 0; j < 1200; j++) begin
                    repeat ($urandom_range(0, 2)) @(posedge sys_clk);
                    #1;
                    issue8(8'(pick(8)), 8'(pick(8)), 1'(j & 1));
                end
            end
        join
        rnd_on = 1'b0;
        @(posedge sys_clk); #2;
        out_ready = 1'b1;
        out_ready8 = 1'b1;
        n = 0;
        while ((exp_q.size() + exp8_q.size()) != 0 && n < 500) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("drain outstanding", 64'(exp_q.size() + exp8_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
